cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle control sequencer that drives the 4×8-bit register file and its program counter. It fetches 8-bit instructions addressed by the PC and decodes them. It reads operands through the register file's asynchronous read ports, computes results in a small internal ALU, and issues write-port and PC-increment strobes. It sits between instruction memory and the register file; the top level drives the register file's active-high reset from ~reset_n.

## Interface
- No parameters; data width fixed at 8 bits, register address width fixed at 2 bits.
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level/pulse; sampled only in IDLE, begins execution.
- instr  input  8  instruction byte at current PC, valid combinationally from imem.
- pc_in  input  8  current PC from the register file (debug/visibility only).
- read_data1  input  8  register file read port 1 data (async).
- read_data2  input  8  register file read port 2 data (async).
- read_addr1  output  2  register file read port 1 address (= rd field).
- read_addr2  output  2  register file read port 2 address (= rs field).
- write_enable  output  1  one-cycle register write strobe.
- write_addr  output  2  destination register.
- write_data  output  8  write data.
- pc_write_enable  output  1  one-cycle PC increment strobe.
- zero_flag, carry_flag  output  1 each  ALU flags.
- halted  output  1  high once HALT executes.
- illegal  output  1  sticky, set on an undefined opcode.
- instr_count  output  8  retired instructions, saturates at 255.

## Operation
- Instruction format: opcode = instr[7:4], rd = instr[3:2], rs = instr[1:0].
- Opcodes:
  - 0 NOP.
  - 1 MOV: rd = rs.
  - 2 ADD: rd = rd + rs.
  - 3 SUB: rd = rd − rs.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: rd = ~rs.
  - 8 LDI: rd = next instruction byte.
  - F HALT.
  - 9–E illegal: set illegal, then execute as NOP.
- States: IDLE, FETCH, DECODE, EXECUTE, IMM_ADV, IMM_FETCH, WRITEBACK, HALT.
- IDLE: start=1 → FETCH. All strobes are 0.
- FETCH: latch instr into IR → DECODE.
- DECODE: read_addr1/2 driven from IR. Next state by opcode:
  - ALU/MOV/NOT → EXECUTE.
  - LDI → IMM_ADV.
  - NOP/illegal → WRITEBACK, with no register write.
  - HALT → HALT.
- EXECUTE: latch result from read_data1/read_data2 → WRITEBACK.
- IMM_ADV: pc_write_enable=1 → IMM_FETCH.
- IMM_FETCH: latch instr as the immediate result → WRITEBACK.
- WRITEBACK: pc_write_enable=1. write_enable=1 only for MOV/ALU/NOT/LDI, with write_addr=rd and write_data=result. instr_count increments (saturating). Next state FETCH.
- HALT: halted=1. No strobes. Stays in HALT until reset; start is ignored.
- Arithmetic: 8-bit wrap-around.
  - ADD: carry = bit 8 of the 9-bit sum.
  - SUB: carry = borrow (rd < rs, unsigned).
  - AND/OR/XOR/NOT: carry cleared.
  - zero = (result == 0) for ALU ops 2–7.
  - MOV, LDI and NOP leave both flags unchanged.
- rd == rs is legal; both operands read the same register (e.g. SUB R1,R1 → 0, zero=1, carry=0).
- The PC is owned by the register file. The sequencer only strobes it, so saturation of the PC is transparent here and the sequencer re-executes the instruction at a saturated PC.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, IR/result/flags/illegal/halted/instr_count = 0. All outputs are 0, including read_addr1/2, write_addr and write_data.
- Strobes are Moore outputs decoded from the state register, high for exactly one cycle per visit.
- Cycles per instruction: ALU/MOV = 4, LDI = 5, NOP/illegal = 3, HALT = 2 (to HALT entry).
- LDI advances the PC twice: once at IMM_ADV and once at WRITEBACK.
- The register write commits at the rising edge ending WRITEBACK. The next instruction's DECODE sees the new value, with no hazard.
- Reset asserted mid-instruction drops all strobes immediately (asynchronous). No partial write is issued after assertion.
- start held high across the return to FETCH has no effect; start is only sampled in IDLE.

## Test plan
- Reset mid-WRITEBACK → write_enable and pc_write_enable fall within the same cycle; state IDLE; all outputs 0.
- imem {0x84, 0x05, 0x88, 0x03, 0x21, 0xF0}, pulse start:
  - R1=0x05, then R2=0x03.
  - ADD R0,R1 (0x21) with R0=0 → R0=0x05, zero=0.
  - halted=1; instr_count=4; 5 pc_write_enable pulses before HALT.
- LDI R0=0xFF; LDI R1=0x01; ADD R0,R1 → R0=0x00, zero=1, carry=1.
- LDI R2=0x02; LDI R3=0x05; SUB R2,R3 → R2=0xFD, carry=1, zero=0. Then MOV R0,R2 → R0=0xFD, flags unchanged.
- Opcode 0xA5 → illegal=1 (sticky); no write_enable; PC advances once; 3 cycles.
- After HALT: pulse start → no strobes for 20 cycles; halted stays 1 until reset_n=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Purpose  : Multi-cycle fetch/decode/execute sequencer for a 4x8-bit
//             register file with an externally owned program counter.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic [7:0] pc_in,
  input  logic [7:0] read_data1,
  input  logic [7:0] read_data2,
  output logic [1:0] read_addr1,
  output logic [1:0] read_addr2,
  output logic       write_enable,
  output logic [1:0] write_addr,
  output logic [7:0] write_data,
  output logic       pc_write_enable,
  output logic       zero_flag,
  output logic       carry_flag,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_IMM_ADV   = 3'd4,
    S_IMM_FETCH = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_MOV  = 4'h1;
  localparam logic [3:0] c_OP_ADD  = 4'h2;
  localparam logic [3:0] c_OP_SUB  = 4'h3;
  localparam logic [3:0] c_OP_AND  = 4'h4;
  localparam logic [3:0] c_OP_OR   = 4'h5;
  localparam logic [3:0] c_OP_XOR  = 4'h6;
  localparam logic [3:0] c_OP_NOT  = 4'h7;
  localparam logic [3:0] c_OP_LDI  = 4'h8;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  state_t     r_state;
  logic [7:0] r_ir;
  logic [7:0] r_result;
  logic       r_zero;
  logic       r_carry;
  logic       r_illegal;
  logic       r_halted;
  logic [7:0] r_count;
  logic       r_we;
  logic       r_pc_we;

  logic [3:0] w_op;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_alu_res;
  logic       w_alu_carry;
  logic [7:0] w_count_inc;
  logic       w_unused_pc;

  assign w_op        = r_ir[7:4];
  assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
  // PC visibility port has no functional role inside the sequencer
  assign w_unused_pc = ^pc_in;

  assign w_sum  = {1'b0, read_data1} + {1'b0, read_data2};
  assign w_diff = {1'b0, read_data1} - {1'b0, read_data2};

  always_comb begin
    w_alu_res   = read_data2;
    w_alu_carry = 1'b0;
    case (w_op)
      c_OP_MOV: w_alu_res = read_data2;
      c_OP_ADD: begin
        w_alu_res   = w_sum[7:0];
        w_alu_carry = w_sum[8];
      end
      c_OP_SUB: begin
        // bit 8 of the 9-bit difference is the unsigned borrow
        w_alu_res   = w_diff[7:0];
        w_alu_carry = w_diff[8];
      end
      c_OP_AND: w_alu_res = read_data1 & read_data2;
      c_OP_OR:  w_alu_res = read_data1 | read_data2;
      c_OP_XOR: w_alu_res = read_data1 ^ read_data2;
      c_OP_NOT: w_alu_res = ~read_data2;
      default:  w_alu_res = read_data2;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ir      <= 8'h00;
      r_result  <= 8'h00;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
      r_halted  <= 1'b0;
      r_count   <= 8'h00;
      r_we      <= 1'b0;
      r_pc_we   <= 1'b0;
    end else begin
      // strobes are registered one-cycle pulses tied to the state being entered
      r_we    <= 1'b0;
      r_pc_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir    <= instr;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (w_op)
            c_OP_MOV, c_OP_ADD, c_OP_SUB, c_OP_AND,
            c_OP_OR, c_OP_XOR, c_OP_NOT: r_state <= S_EXECUTE;
            c_OP_LDI: begin
              r_state <= S_IMM_ADV;
              r_pc_we <= 1'b1;
            end
            c_OP_HALT: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
              r_count  <= w_count_inc;
            end
            default: begin
              if (w_op != c_OP_NOP) r_illegal <= 1'b1;
              r_state <= S_WRITEBACK;
              r_pc_we <= 1'b1;
            end
          endcase
        end
        S_EXECUTE: begin
          r_result <= w_alu_res;
          if (w_op != c_OP_MOV) begin
            r_zero  <= (w_alu_res == 8'h00);
            r_carry <= w_alu_carry;
          end
          r_state <= S_WRITEBACK;
          r_we    <= 1'b1;
          r_pc_we <= 1'b1;
        end
        S_IMM_ADV: begin
          r_state <= S_IMM_FETCH;
        end
        S_IMM_FETCH: begin
          r_result <= instr;
          r_state  <= S_WRITEBACK;
          r_we     <= 1'b1;
          r_pc_we  <= 1'b1;
        end
        S_WRITEBACK: begin
          r_count <= w_count_inc;
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_addr1      = r_ir[3:2];
  assign read_addr2      = r_ir[1:0];
  assign write_addr      = r_ir[3:2];
  assign write_data      = r_result;
  assign write_enable    = r_we;
  assign pc_write_enable = r_pc_we;
  assign zero_flag       = r_zero;
  assign carry_flag      = r_carry;
  assign halted          = r_halted;
  assign illegal         = r_illegal;
  assign instr_count     = r_count;

endmodule
`default_nettype wire
